// File: rtl/rename_pkg.sv
// Shared constants and types for the rename stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rename_pkg;

  localparam int NUM_ARCH   = 32;
  localparam int NUM_PHYS   = 64;
  localparam int FREE_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int ARCH_W     = 5;
  localparam int PHYS_W     = 6;
  localparam int CNT_W      = $clog2(FREE_DEPTH + 1);

  typedef logic [ARCH_W-1:0] areg_t;
  typedef logic [PHYS_W-1:0] preg_t;

  localparam preg_t PREG_ZERO = '0;

  // x0 is hardwired, so writes to it never consume a physical register.
  function automatic logic needs_alloc(input logic rd_wr, input areg_t rd);
    return rd_wr && (rd != '0);
  endfunction

endpackage

// File: rtl/free_list_fifo.sv
// Circular free list of physical register tags, reset-loaded with BASE..BASE+DEPTH-1.
// Latency: head_data is a combinational read of the head slot; pops and pushes take effect on the next edge.
// Backpressure: caller must not pop when empty; a push into a full list is dropped and flagged sticky unless a pop frees a slot that edge.
module free_list_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 6,
  parameter int BASE  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc,
  input  logic                         free,
  input  logic [WIDTH-1:0]             free_data,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;

  assign head_data = mem[head];

  // A full list still accepts a push when the same edge pops the head.
  assign push = free && ((count != CW'(DEPTH)) || alloc);

  // Pointer, storage, occupancy and sticky overflow update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(BASE + i);
      end
      head     <= '0;
      tail     <= '0;
      count    <= CW'(DEPTH);
      overflow <= 1'b0;
    end else begin
      if (alloc) begin
        head <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
      end
      if (push) begin
        mem[tail] <= free_data;
        tail      <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;
      end
      if (free && !push) begin
        overflow <= 1'b1;
      end
      if (alloc && !push) begin
        count <= count - 1'b1;
      end else if (push && !alloc) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_rename.sv
// Rename stage: maps architectural sources/destination through the RAT and allocates from the free list.
// Latency: 1 cycle, registered outputs; payload holds on idle cycles.
// Backpressure: in_ready drops when the free list is empty (from registered count only).
module register_rename
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ARCH_W-1:0] in_rs1,
  input  logic [ARCH_W-1:0] in_rs2,
  input  logic [ARCH_W-1:0] in_rd,
  input  logic              in_rd_wr,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  output logic [PHYS_W-1:0] out_ps1,
  output logic [PHYS_W-1:0] out_ps2,
  output logic [PHYS_W-1:0] dest_reg,
  output logic [PHYS_W-1:0] old_dest_reg,
  output logic [31:0]       PC,
  input  logic              retire_valid,
  input  logic [PHYS_W-1:0] retire_old_pd,
  output logic [CNT_W-1:0]  free_count,
  output logic              overflow_err
);

  preg_t rat [NUM_ARCH];
  preg_t head_pd;
  logic  accept;
  logic  do_alloc;
  logic  do_free;

  assign in_ready = (free_count != '0);
  assign accept   = in_valid && in_ready;
  assign do_alloc = accept && needs_alloc(in_rd_wr, in_rd);
  assign do_free  = retire_valid && (retire_old_pd != PREG_ZERO);

  free_list_fifo #(
    .DEPTH (FREE_DEPTH),
    .WIDTH (PHYS_W),
    .BASE  (NUM_ARCH)
  ) u_free_list (
    .clk       (clk),
    .reset     (reset),
    .alloc     (do_alloc),
    .free      (do_free),
    .free_data (retire_old_pd),
    .head_data (head_pd),
    .count     (free_count),
    .overflow  (overflow_err)
  );

  // RAT update and output register; sources read the pre-update mapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat[i] <= PHYS_W'(i);
      end
      out_valid    <= 1'b0;
      out_ps1      <= PREG_ZERO;
      out_ps2      <= PREG_ZERO;
      dest_reg     <= PREG_ZERO;
      old_dest_reg <= PREG_ZERO;
      PC           <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_ps1      <= rat[in_rs1];
        out_ps2      <= rat[in_rs2];
        PC           <= in_pc;
        dest_reg     <= do_alloc ? head_pd : PREG_ZERO;
        old_dest_reg <= do_alloc ? rat[in_rd] : PREG_ZERO;
      end
      if (do_alloc) begin
        rat[in_rd] <= head_pd;
      end
    end
  end

endmodule
